// File: rtl/reg_file_nrw.sv
// ---------------------------------------------------------------------------
// reg_file_nrw: parametrised architectural register bank.
//
// The bank holds DEPTH words of WIDTH bits each. Every word is a D-type
// register with its own write enable. There is one synchronous write port
// and there are two combinational read ports. ZERO_REG names an optional
// index that always reads as zero. A write to it, or to any index at or
// above DEPTH, is dropped. When BYPASS is set, write data that is being
// committed in the current cycle is forwarded to any read port that
// addresses the same word. wr_count counts committed writes since reset
// and saturates at 16'hFFFF.
//
// Ports:
//   clk       in   1      clock; all state updates on the rising edge
//   reset     in   1      synchronous, active-high; clears words and counter
//   wr_en     in   1      write enable
//   wr_addr   in   AW     write register index
//   wr_data   in   WIDTH  write data
//   rd_addr1  in   AW     read port 1 index
//   rd_addr2  in   AW     read port 2 index
//   rd_data1  out  WIDTH  read port 1 data (combinational)
//   rd_data2  out  WIDTH  read port 2 data (combinational)
//   wr_count  out  16     committed writes since reset, saturating
// ---------------------------------------------------------------------------
module reg_file_nrw #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 32,
    parameter int          ZERO_REG = 31,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic [15:0]      wr_count
);

    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A ZERO_REG value outside 0..DEPTH-1 (for example -1) disables the
    // zero register. The indices it would name are out of range anyway.
    localparam bit HAS_ZERO = (ZERO_REG >= 0) && (ZERO_REG < int'(DEPTH));
    localparam logic [31:0] ZERO_IDX = HAS_ZERO ? ZERO_REG : 0;
    localparam logic [31:0] DEPTH_U  = DEPTH;
    localparam bit BYPASS_ON = (BYPASS != 0);

    // Address classification. The address is widened to 32 bits, so the
    // comparisons work the same way whether or not DEPTH is a power of two.
    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        logic [31:0] a;
        a = 32'(addr);
        return a < DEPTH_U;
    endfunction

    function automatic logic addr_is_zero(input logic [AW-1:0] addr);
        logic [31:0] a;
        a = 32'(addr);
        return HAS_ZERO && (a == ZERO_IDX);
    endfunction

    // -----------------------------------------------------------------------
    // Storage and write path
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] word_we;
    logic             wr_commit;

    // reset takes priority, so a write in a reset cycle never commits.
    // This also blocks the bypass path while reset is high.
    always_comb begin
        wr_commit = wr_en && !reset && addr_in_range(wr_addr) && !addr_is_zero(wr_addr);
    end

    // Decode the write address into one enable per word.
    always_comb begin
        word_we = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            word_we[i] = wr_commit && (32'(wr_addr) == i);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (reset) begin
                mem_q[i] <= '0;
            end else if (word_we[i]) begin
                mem_q[i] <= wr_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Committed-write counter (saturating)
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] wr_count_q, wr_count_d;

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_commit && (wr_count_q != CNT_MAX)) begin
            wr_count_d = wr_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_count = wr_count_q;

    // -----------------------------------------------------------------------
    // Read ports
    // -----------------------------------------------------------------------
    // The zero register and out-of-range indices are checked first. As a
    // result, the bypass path can never forward data to the zero register.
    // An in-range, non-zero address match also means the write commits.
    logic rd1_valid, rd2_valid;
    logic rd1_hit, rd2_hit;

    always_comb begin
        rd1_valid = addr_in_range(rd_addr1) && !addr_is_zero(rd_addr1);
        rd2_valid = addr_in_range(rd_addr2) && !addr_is_zero(rd_addr2);
        rd1_hit   = BYPASS_ON && wr_en && !reset && (wr_addr == rd_addr1);
        rd2_hit   = BYPASS_ON && wr_en && !reset && (wr_addr == rd_addr2);
    end

    always_comb begin
        rd_data1 = '0;
        if (rd1_valid) begin
            if (rd1_hit) begin
                rd_data1 = wr_data;
            end else begin
                rd_data1 = mem_q[rd_addr1];
            end
        end
    end

    always_comb begin
        rd_data2 = '0;
        if (rd2_valid) begin
            if (rd2_hit) begin
                rd_data2 = wr_data;
            end else begin
                rd_data2 = mem_q[rd_addr2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_nrw.sv
// ---------------------------------------------------------------------------
// tb_reg_file_nrw: directed self-checking bench for reg_file_nrw.
//
// Three builds share one set of stimulus:
//   dut_bp  - WIDTH=64, DEPTH=32, ZERO_REG=31, BYPASS=1
//   dut_nb  - WIDTH=64, DEPTH=32, ZERO_REG=31, BYPASS=0
//   dut_d20 - WIDTH=64, DEPTH=20, ZERO_REG=-1, BYPASS=1
// Inputs change 1 time unit after a rising edge. Outputs are sampled
// 1 time unit after that, which is well away from the next edge.
// ---------------------------------------------------------------------------
module tb_reg_file_nrw;

    localparam logic [63:0] PAT_A = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] PAT_B = 64'h0000_0000_0000_0ABC;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;

    logic [63:0] bp_rd1, bp_rd2, nb_rd1, nb_rd2, d20_rd1, d20_rd2;
    logic [15:0] bp_cnt, nb_cnt, d20_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_nrw #(.WIDTH(64), .DEPTH(32), .ZERO_REG(31), .BYPASS(1)) dut_bp (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (bp_rd1),
        .rd_data2 (bp_rd2),
        .wr_count (bp_cnt)
    );

    reg_file_nrw #(.WIDTH(64), .DEPTH(32), .ZERO_REG(31), .BYPASS(0)) dut_nb (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (nb_rd1),
        .rd_data2 (nb_rd2),
        .wr_count (nb_cnt)
    );

    reg_file_nrw #(.WIDTH(64), .DEPTH(20), .ZERO_REG(-1), .BYPASS(1)) dut_d20 (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (d20_rd1),
        .rd_data2 (d20_rd2),
        .wr_count (d20_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive a complete input vector, then wait for the combinational paths
    // to settle.
    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic [4:0] ra1,
                         input logic [4:0] ra2);
        reset    = rst;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr1 = ra1;
        rd_addr2 = ra2;
        #1;
    endtask

    // Advance past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);

        // Reset then read
        step();
        step();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd30);
        check("rst_rd1",     bp_rd1,  64'd0);
        check("rst_rd2",     bp_rd2,  64'd0);
        check("rst_cnt",     64'(bp_cnt),  64'd0);
        check("rst_nb_rd1",  nb_rd1,  64'd0);
        check("rst_d20_cnt", 64'(d20_cnt), 64'd0);

        // Write reg 5 with one-cycle latency, plus bypass
        drive(1'b0, 1'b1, 5'd5, PAT_A, 5'd5, 5'd5);
        check("nb_pre_edge",  nb_rd1, 64'd0);
        check("bp_byp_rd1",   bp_rd1, PAT_A);
        check("bp_byp_rd2",   bp_rd2, PAT_A);
        step();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5);
        check("nb_post_edge", nb_rd1, PAT_A);
        check("bp_persist1",  bp_rd1, PAT_A);
        check("bp_persist2",  bp_rd2, PAT_A);
        check("nb_cnt1",      64'(nb_cnt), 64'd1);
        check("bp_cnt1",      64'(bp_cnt), 64'd1);

        // Zero register: the write is dropped and the bypass never shows it
        drive(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd5);
        check("zero_byp_bp", bp_rd1, 64'd0);
        check("zero_byp_nb", nb_rd1, 64'd0);
        step();
        drive(1'b0, 1'b0, 5'd5, 64'd7, 5'd31, 5'd5);
        check("zero_after",  bp_rd1, 64'd0);
        check("hold_r5",     bp_rd2, PAT_A);
        check("zero_cnt",    64'(bp_cnt), 64'd1);
        step();
        check("hold_r5_nb",  nb_rd2, PAT_A);
        check("hold_cnt",    64'(nb_cnt), 64'd1);

        // Out-of-range write (DEPTH=20); in range for the 32-deep builds
        drive(1'b0, 1'b1, 5'd25, PAT_B, 5'd25, 5'd5);
        check("oor_pre_d20", d20_rd1, 64'd0);
        check("oor_pre_bp",  bp_rd1,  PAT_B);
        check("oor_pre_nb",  nb_rd1,  64'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd25, 5'd5);
        check("oor_d20_rd",  d20_rd1, 64'd0);
        check("oor_d20_r5",  d20_rd2, PAT_A);
        check("oor_d20_cnt", 64'(d20_cnt), 64'd1);
        check("oor_bp_rd",   bp_rd1,  PAT_B);
        check("oor_bp_cnt",  64'(bp_cnt), 64'd2);

        // Reset priority in the middle of operation
        drive(1'b0, 1'b1, 5'd3, 64'h11, 5'd3, 5'd5);
        step();
        drive(1'b1, 1'b1, 5'd3, 64'h22, 5'd3, 5'd5);
        check("pre_rst_cnt", 64'(bp_cnt), 64'd3);
        check("rst_no_byp",  bp_rd1, 64'h11);
        step();
        drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd5);
        check("rprio_r3",    bp_rd1, 64'd0);
        check("rprio_r5",    bp_rd2, 64'd0);
        check("rprio_cnt",   64'(bp_cnt), 64'd0);
        check("rprio_nb_r3", nb_rd1, 64'd0);

        // Saturation: 70000 committed writes to reg 0
        for (int i = 0; i < 70000; i++) begin
            drive(1'b0, 1'b1, 5'd0, 64'(i), 5'd0, 5'd0);
            if (i == 1) check("sat_nb_nobyp", nb_rd1, 64'd0);
            step();
            if (i == 65533) check("sat_fffe", 64'(bp_cnt), 64'hFFFE);
            if (i == 65534) check("sat_ffff", 64'(bp_cnt), 64'hFFFF);
        end
        drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        check("sat_bp_cnt",  64'(bp_cnt),  64'hFFFF);
        check("sat_nb_cnt",  64'(nb_cnt),  64'hFFFF);
        check("sat_d20_cnt", 64'(d20_cnt), 64'hFFFF);
        check("sat_last_rd", d20_rd1, 64'd69999);
        check("sat_nb_rd",   nb_rd1,  64'd69999);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_nrw.md
Name: reg_file_nrw

Overview:
- Parametrised register file: array of enable-gated D-type storage words with one synchronous write port and two combinational read ports.
- Forms the architectural register bank of the single-cycle/pipelined CPU datapath, between the decode stage and the ALU.
- Compared with a single-bit enable flop, it adds:
  - configurable width and depth;
  - a hard-wired zero register;
  - optional write-to-read bypass;
  - an aggregate write counter for debug.

Parameters:
- WIDTH, 64, bits per register.
- DEPTH, 32, number of registers; need not be a power of two.
- AW, $clog2(DEPTH), address width (derived, not overridden).
- ZERO_REG, 31, index hard-wired to zero; -1 disables the zero register.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return the stored value only.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write register index.
- wr_data  in  WIDTH  write data.
- rd_addr1  in  AW  read port 1 index.
- rd_addr2  in  AW  read port 2 index.
- rd_data1  out  WIDTH  read port 1 data, combinational.
- rd_data2  out  WIDTH  read port 2 data, combinational.
- wr_count  out  16  number of committed writes since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (clk posedge with reset=1):
  - all DEPTH registers <= 0; wr_count <= 0.
  - reset has priority over wr_en in the same cycle; the write is discarded.
  - Asserting reset mid-stream loses all contents at that edge.
- Write:
  - on posedge with reset=0, wr_en=1, wr_addr<DEPTH and wr_addr!=ZERO_REG: mem[wr_addr] <= wr_data.
  - Latency one cycle: the value is visible to non-bypassed reads after that edge.
  - wr_count increments by 1 only for committed writes.
- Ignored writes:
  - a write to ZERO_REG, or to wr_addr>=DEPTH, leaves storage unchanged and does not increment wr_count.
  - wr_en=0 holds all registers (enable semantics per word).
- Read (combinational, per port independently):
  - rd_addr==ZERO_REG -> 0.
  - rd_addr>=DEPTH -> 0.
  - else if BYPASS=1 and wr_en=1 and reset=0 and wr_addr==rd_addr -> wr_data.
  - else -> mem[rd_addr].
- Both read ports may address the same register; both return identical data.
- The zero register must read 0 even immediately after an attempted write to it, including on the bypass path.
- wr_count saturation: at 16'hFFFF, further committed writes leave it at 16'hFFFF.
- No X propagation: the first cycle after reset, all reads return 0.
- Storage outside reset must not be initialised by simulation-only constructs; reset is the only initialiser.

Test Plan (WIDTH=64, DEPTH=32, ZERO_REG=31 unless noted):
- Reset then read:
  - stimulus: reset=1 for 2 cycles, then rd_addr1=5, rd_addr2=30.
  - required: rd_data1=0, rd_data2=0, wr_count=0.
- Write/read with one-cycle latency (BYPASS=0 build):
  - stimulus: wr_en=1, wr_addr=5, wr_data=64'hDEAD_BEEF_0123_4567, rd_addr1=5.
  - required: rd_data1=0 before the edge and 64'hDEAD_BEEF_0123_4567 after it; wr_count=1.
- Bypass (BYPASS=1):
  - stimulus: same write; rd_addr1=5 and rd_addr2=5 in the same cycle.
  - required: both ports equal 64'hDEAD_BEEF_0123_4567 before the edge; the value persists after wr_en=0.
- Zero register and hold:
  - stimulus: wr_en=1, wr_addr=31, wr_data=64'hFFFF_FFFF_FFFF_FFFF, rd_addr1=31; then wr_en=0, wr_addr=5, wr_data=7.
  - required: rd_data1=0 at all times; mem[5] unchanged; wr_count unchanged.
- Reset priority mid-operation:
  - stimulus: write 64'h11 to reg 3; next cycle assert reset=1 together with wr_en=1, wr_addr=3, wr_data=64'h22.
  - required: after that edge, reg 3 reads 0 and wr_count=0.
- Out-of-range address and saturation (DEPTH=20 build):
  - stimulus: write to wr_addr=25, read rd_addr1=25; then preload wr_count near limit and issue 70000 writes to reg 0.
  - required: no storage changes from the out-of-range write and rd_data1=0; wr_count stops at 16'hFFFF.
